vram_scan_arbiter: RTL and testbench

- Owns the single port of the on-chip frame memory and shares it between two requesters: the VGA scanout path (pixel fetch driven by the 1024x768 timing generator's visible coordinates) and a pixel writer (drawing logic).
- Scanout always has priority. Writes are buffered in a small FIFO and retired on free memory cycles.
- The frame memory holds a downscaled 256x192 RGB444 image, replicated 4x4 on screen.

---
 rtl/vram_scan_arbiter_pkg.sv | 21 ++
 rtl/vram_scan_arbiter_if.sv | 30 +++
 rtl/vram_wr_fifo.sv | 46 ++++
 rtl/vram_scan_arbiter.sv | 104 ++++++++++
 tb/tb_vram_scan_arbiter.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/vram_scan_arbiter_pkg.sv
// vram_scan_arbiter_pkg: framebuffer geometry, grant encoding and pixel types shared with the drawing logic
package vram_scan_arbiter_pkg;
    localparam int FB_W        = 256;
    localparam int FB_H        = 192;
    localparam int SCALE_SHIFT = 2;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 12;
    localparam int WFIFO_DEPTH = 4;
    localparam int FB_WORDS    = FB_W * FB_H;

    typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_WRITE, GNT_CLEAR} gnt_e;
    typedef logic [DATA_W-1:0] pix_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        pix_t              data;
    } wr_ent_t;

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [10:0] x, input logic [10:0] y);
        return ADDR_W'(int'(y >> SCALE_SHIFT) * FB_W + int'(x >> SCALE_SHIFT));
    endfunction
endpackage

// File: rtl/vram_scan_arbiter_if.sv
// vram_scan_arbiter_if: scanout, writer, memory and clear signals of the frame memory arbiter
interface vram_scan_arbiter_if;
    import vram_scan_arbiter_pkg::*;
    logic              disp_req;
    logic [10:0]       disp_x;
    logic [10:0]       disp_y;
    pix_t              pix_data;
    logic              pix_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    pix_t              wr_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    pix_t              mem_wdata;
    pix_t              mem_rdata;
    logic              clr_start;
    pix_t              clr_color;
    logic              clr_busy;

    modport master (
        output disp_req, disp_x, disp_y, wr_valid, wr_addr, wr_data, mem_rdata, clr_start, clr_color,
        input  pix_data, pix_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata, clr_busy
    );
    modport slave (
        input  disp_req, disp_x, disp_y, wr_valid, wr_addr, wr_data, mem_rdata, clr_start, clr_color,
        output pix_data, pix_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata, clr_busy
    );
endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous write FIFO with registered ready and no fall-through
module vram_wr_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 4
) (
    input  logic         clk_vga,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         ready_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q, do_push, do_pop;

    assign ready_o = ready_q;
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rp_q];
    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && !empty_o;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk_vga) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

    // ready follows next-state occupancy, so a pop on a full FIFO frees the slot one cycle later
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop) rp_q <= rp_q + AW'(1);
            cnt_q   <= cnt_d;
            ready_q <= cnt_d != (AW+1)'(DEPTH);
        end
    end
endmodule

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: frame memory port arbiter, scanout over buffered writes; VRAM_CLEAR_EN adds a background clear
module vram_scan_arbiter
    import vram_scan_arbiter_pkg::*;
(
    input logic                clk_vga,
    input logic                rst_n,
    vram_scan_arbiter_if.slave bus
);
    gnt_e              gnt;
    wr_ent_t           head;
    logic              fifo_empty, fifo_ready, disp_hit, clr_pend;
    logic [ADDR_W-1:0] clr_addr;
    pix_t              clr_data;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    pix_t              mem_wdata_q, mem_wdata_d, pix_data_q;
    logic              v1_q, r1_q, v2_q, r2_q, pix_valid_q;

    assign disp_hit = bus.disp_req && (bus.disp_x >> SCALE_SHIFT) < 11'(FB_W)
                                   && (bus.disp_y >> SCALE_SHIFT) < 11'(FB_H);

    vram_wr_fifo #(.W($bits(wr_ent_t)), .DEPTH(WFIFO_DEPTH)) u_fifo (
        .clk_vga (clk_vga),
        .rst_n   (rst_n),
        .push_i  (bus.wr_valid),
        .pop_i   (gnt == GNT_WRITE),
        .din_i   ({bus.wr_addr, bus.wr_data}),
        .dout_o  (head),
        .empty_o (fifo_empty),
        .ready_o (fifo_ready)
    );

    always_comb begin
        gnt         = disp_hit ? GNT_DISP : !fifo_empty ? GNT_WRITE : clr_pend ? GNT_CLEAR : GNT_IDLE;
        mem_en_d    = gnt != GNT_IDLE;
        mem_we_d    = gnt == GNT_WRITE || gnt == GNT_CLEAR;
        mem_addr_d  = gnt == GNT_DISP  ? fb_addr(bus.disp_x, bus.disp_y) :
                      gnt == GNT_WRITE ? head.addr :
                      gnt == GNT_CLEAR ? clr_addr : '0;
        mem_wdata_d = gnt == GNT_WRITE ? head.data : gnt == GNT_CLEAR ? clr_data : '0;
    end

    // read pipeline tracks request and in-range separately so out-of-range pixels return 0 on time
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            {mem_en_q, mem_we_q, v1_q, r1_q, v2_q, r2_q, pix_valid_q} <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pix_data_q  <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            v1_q        <= bus.disp_req;
            r1_q        <= disp_hit;
            v2_q        <= v1_q;
            r2_q        <= r1_q;
            pix_valid_q <= v2_q;
            pix_data_q  <= r2_q ? bus.mem_rdata : '0;
        end
    end

`ifdef VRAM_CLEAR_EN
    logic              clr_busy_q, clr_fin_q;
    logic [ADDR_W-1:0] clr_cnt_q;

    assign clr_pend     = clr_busy_q && !clr_fin_q;
    assign clr_addr     = clr_cnt_q;
    assign clr_data     = bus.clr_color;
    assign bus.clr_busy = clr_busy_q;

    // busy holds through the cycle that performs the final write
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            clr_busy_q <= 1'b0;
            clr_fin_q  <= 1'b0;
            clr_cnt_q  <= '0;
        end else if (!clr_busy_q) begin
            clr_busy_q <= bus.clr_start;
            clr_cnt_q  <= '0;
        end else if (clr_fin_q) begin
            clr_busy_q <= 1'b0;
            clr_fin_q  <= 1'b0;
        end else if (gnt == GNT_CLEAR) begin
            clr_fin_q <= clr_cnt_q == ADDR_W'(FB_WORDS - 1);
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
    end
`else
    assign clr_pend     = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
    assign bus.clr_busy = 1'b0;
`endif

    assign bus.pix_data  = pix_data_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.wr_ready  = fifo_ready;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb_vram_scan_arbiter: random and directed traffic against a queue-based memory/FIFO reference model
module tb_vram_scan_arbiter;
    import vram_scan_arbiter_pkg::*;
`ifdef VRAM_CLEAR_EN
    localparam bit HAS_CLR = 1'b1;
`else
    localparam bit HAS_CLR = 1'b0;
`endif

    logic clk_vga = 1'b0;
    logic rst_n   = 1'b0;
    vram_scan_arbiter_if bus ();
    vram_scan_arbiter dut (.clk_vga(clk_vga), .rst_n(rst_n), .bus(bus));
    always #5 clk_vga = ~clk_vga;

    logic [11:0] mem_arr [65536];
    always @(posedge clk_vga) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem_arr[bus.mem_addr];
        end
    end

    int          n_tests, n_fail, cyc;
    bit          e_en, e_we, m_ready, m_busy, m_fin;
    logic [15:0] e_addr;
    logic [11:0] e_wdata, cc;
    bit          rval [8];
    logic [11:0] rdat [8];
    logic [27:0] q [$];
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        m_ready = 1; m_busy = 0; m_fin = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) begin rval[i] = 0; rdat[i] = '0; end
    endtask

    task automatic drive_idle();
        bus.disp_req = 0; bus.disp_x = '0; bus.disp_y = '0;
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clr_start = 0; bus.clr_color = cc;
    endtask

    task automatic do_reset();
        @(negedge clk_vga);
        rst_n = 0; bus.wr_valid = 1; bus.disp_req = 1; bus.clr_start = 1;
        bus.wr_addr = 16'h4321; bus.disp_x = 11'd40; bus.disp_y = 11'd40;
        repeat (3) begin
            @(negedge clk_vga);
            check("rst_pix_valid", bus.pix_valid, 0);
            check("rst_pix_data", bus.pix_data, 0);
            check("rst_mem_en", bus.mem_en, 0);
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_wr_ready", bus.wr_ready, 1);
            check("rst_clr_busy", bus.clr_busy, 0);
        end
        rst_n = 1;
        drive_idle();
        model_reset();
    endtask

    task automatic step(input bit dr, input logic [10:0] x, input logic [10:0] y, input bit wv,
                        input logic [15:0] wa, input logic [11:0] wd, input bit cs);
        int fx, fy;
        bit hit, acc, gclr;
        logic [27:0] w;
        @(negedge clk_vga);
        check("mem_en", bus.mem_en, e_en);
        check("mem_we", bus.mem_we, e_we);
        if (e_en) check("mem_addr", bus.mem_addr, e_addr);
        if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
        if (e_en && !e_we) rdat[(cyc + 2) % 8] = mem_arr[e_addr];
        check("pix_valid", bus.pix_valid, rval[cyc % 8]);
        if (rval[cyc % 8]) check("pix_data", bus.pix_data, rdat[cyc % 8]);
        rval[cyc % 8] = 0;
        check("wr_ready", bus.wr_ready, m_ready);
        check("clr_busy", bus.clr_busy, m_busy);
        bus.disp_req = dr; bus.disp_x = x; bus.disp_y = y;
        bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
        bus.clr_start = cs; bus.clr_color = cc;
        fx = int'(x) / 4;
        fy = int'(y) / 4;
        hit = dr && fx < FB_W && fy < FB_H;
        rval[(cyc + 3) % 8] = dr;
        rdat[(cyc + 3) % 8] = '0;
        acc = wv && m_ready;
        gclr = 0;
        e_en = 0; e_we = 0;
        if (hit) begin
            e_en = 1; e_addr = 16'(fy * FB_W + fx);
        end else if (q.size() > 0) begin
            w = q.pop_front();
            e_en = 1; e_we = 1; e_addr = w[27:12]; e_wdata = w[11:0];
        end else if (m_busy && !m_fin) begin
            gclr = 1; e_en = 1; e_we = 1; e_addr = 16'(m_cnt); e_wdata = cc;
        end
        if (!m_busy) begin
            m_busy = cs && HAS_CLR; m_cnt = 0;
        end else if (m_fin) begin
            m_busy = 0; m_fin = 0;
        end else if (gclr) begin
            m_fin = m_cnt == FB_WORDS - 1; m_cnt++;
        end
        if (acc) q.push_back({wa, wd});
        m_ready = q.size() < WFIFO_DEPTH;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, '0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = 12'($urandom);
        cc = 12'h0F0;
        drive_idle();
        model_reset();
        do_reset();
        mem_arr[16'h0102] = 12'hABC;
        step(1, 11'd8, 11'd4, 0, '0, '0, 0);
        idle(4);
        step(1, 11'd8, 11'd4, 1, 16'h1234, 12'h555, 0);
        step(1, 11'd0, 11'd780, 0, '0, '0, 0);
        idle(4);
        for (int i = 0; i < 8; i++) step(1, 11'(100 + i), 11'd200, i < 5, 16'(i * 7 + 3), 12'(i + 1), 0);
        idle(8);
        for (int i = 0; i < 4; i++) step(1, 11'(300 + i), 11'd20, 1, 16'(i + 40), 12'(i + 9), 0);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 16'(i + 50), 12'(i + 20), 0);
        idle(8);
        step(1, 11'd1023, 11'd767, 0, '0, '0, 0);
        step(1, 11'd1024, 11'd0, 0, '0, '0, 0);
        idle(4);
        repeat (3000)
            step($urandom_range(0, 9) < 7, 11'($urandom_range(0, 1100)), 11'($urandom_range(0, 820)),
                 $urandom_range(0, 2) == 0, 16'($urandom), 12'($urandom), 0);
        idle(8);
        step(0, '0, '0, 0, '0, '0, 1);
        for (int i = 0; i < (HAS_CLR ? FB_WORDS + 48 : 20); i++)
            step(0, '0, '0, i == 100, 16'hBEEF, 12'h123, 0);
        repeat (6) step(1, 11'($urandom_range(0, 1023)), 11'($urandom_range(0, 767)), 1, 16'($urandom), 12'($urandom), 0);
        do_reset();
        idle(6);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
